w452_ifq: RTL and testbench

- Instruction fetch queue that sits directly upstream of the w452 multi-cycle core's decode.
- Streams 16-bit instruction halfwords from the instruction read port (mem_rd0) into a small FIFO. Each entry is tagged with its halfword address.
- Presents entries to the core over a valid/ready handshake. Decouples fetch from the 5-state execute sequence.
- A redirect input (taken branch, JR/JRL) flushes the queue and restarts fetch at a new address.

---
 rtl/w452_ifq_if.sv | 28 ++
 rtl/w452_ifq.sv | 82 ++++++++
 tb/tb_w452_ifq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/w452_ifq_if.sv
// Bundles the w452 fetch-queue signals.
// The master side is the queue; the slave side is instruction memory plus the consuming core.
interface w452_ifq_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [30:0]   mem_rd0_addr;
    logic [15:0]   mem_rd0_data;
    logic          fetch_en;
    logic          redirect_valid;
    logic [30:0]   redirect_pc;
    logic          instr_valid;
    logic [15:0]   instr;
    logic [30:0]   instr_pc;
    logic          instr_ready;
    logic [CW-1:0] count;

    modport master (
        output mem_rd0_addr, instr_valid, instr, instr_pc, count,
        input  mem_rd0_data, fetch_en, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_rd0_addr, instr_valid, instr, instr_pc, count,
        output mem_rd0_data, fetch_en, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/w452_ifq.sv
// Instruction fetch queue: streams halfwords from mem_rd0 into a small FIFO tagged with their address.
// A redirect flushes the queue and restarts fetch at a new address.
module w452_ifq #(
    parameter int          DEPTH    = 4,
    parameter logic [30:0] RESET_PC = 31'h0
) (
    input logic          clk,
    input logic          reset,
    w452_ifq_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [46:0]   entries_q [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [30:0]   fetchPc_q, fetchPc_d;
    logic          notEmpty, notFull, push, pop;
    logic [46:0]   headEntry;

    // A full queue may still accept a push in the same cycle it pops.
    always_comb begin
        notEmpty  = (count_q != '0);
        notFull   = (count_q < CW'(DEPTH));
        pop       = notEmpty & bus.instr_ready & ~bus.redirect_valid;
        push      = bus.fetch_en & ~bus.redirect_valid & (notFull | pop);
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        fetchPc_d = fetchPc_q;
        if (bus.redirect_valid) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            fetchPc_d = bus.redirect_pc;
        end else begin
            if (push) begin
                wrPtr_d   = wrPtr_q + PW'(1);
                fetchPc_d = fetchPc_q + 31'd1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            fetchPc_q <= RESET_PC;
        end else begin
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            fetchPc_q <= fetchPc_d;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wrPtr_q] <= {bus.mem_rd0_data, fetchPc_q};
        end
    end

    always_comb begin
        headEntry        = entries_q[rdPtr_q];
        bus.mem_rd0_addr = fetchPc_q;
        bus.instr_valid  = notEmpty;
        bus.instr        = notEmpty ? headEntry[46:31] : 16'h0;
        bus.instr_pc     = notEmpty ? headEntry[30:0]  : 31'h0;
        bus.count        = count_q;
    end
endmodule

// File: tb/tb_w452_ifq.sv
// Randomised and directed bench for w452_ifq.
// A queue-based reference model feeds a scoreboard that checks every cycle.
module tb_w452_ifq;
    localparam int          DEPTH    = 4;
    localparam logic [30:0] RESET_PC = 31'h10;

    typedef struct packed {
        logic [15:0] data;
        logic [30:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   monEn = 1'b0;
    int   tests = 0;
    int   errors = 0;
    ent_t expQ[$];
    logic [30:0] modelPc;

    always #5 clk = ~clk;

    w452_ifq_if #(.DEPTH(DEPTH)) bus ();

    w452_ifq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: word[h] = h ^ 16'hA5A5.
    assign bus.mem_rd0_data = bus.mem_rd0_addr[15:0] ^ 16'hA5A5;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic rv, input logic [30:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
    endtask

    // Reference model: the queue contents themselves; fetch appends while space remains.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            expQ.delete();
            modelPc = RESET_PC;
        end else if (bus.redirect_valid) begin
            expQ.delete();
            modelPc = bus.redirect_pc;
        end else if (bus.fetch_en && expQ.size() < DEPTH) begin
            expQ.push_back(ent_t'({modelPc[15:0] ^ 16'hA5A5, modelPc}));
            modelPc = modelPc + 31'd1;
        end
    end

    // Monitor: compare the DUT to the model, and retire the head on an accepted handshake.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("count", 64'(bus.count), 64'(expQ.size()));
            checkOutput("instr_valid", 64'(bus.instr_valid), 64'(expQ.size() != 0));
            checkOutput("mem_rd0_addr", 64'(bus.mem_rd0_addr), 64'(modelPc));
            if (expQ.size() != 0) begin
                checkOutput("instr", 64'(bus.instr), 64'(expQ[0].data));
                checkOutput("instr_pc", 64'(bus.instr_pc), 64'(expQ[0].pc));
                if (bus.instr_ready && !bus.redirect_valid && !reset) begin
                    void'(expQ.pop_front());
                end
            end else begin
                checkOutput("instr_empty", 64'(bus.instr), 64'(0));
                checkOutput("instr_pc_empty", 64'(bus.instr_pc), 64'(0));
            end
        end
    end

    initial begin
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 31'h0;
        bus.instr_ready    = 1'b0;
        #1 reset = 1'b1;
        monEn = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fill to full with the consumer stalled.
        repeat (6) applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        checkOutput("full_count", 64'(bus.count), 64'(4));
        checkOutput("full_addr", 64'(bus.mem_rd0_addr), 64'h14);
        checkOutput("full_instr", 64'(bus.instr), 64'hA5B5);
        checkOutput("full_pc", 64'(bus.instr_pc), 64'h10);

        // Streaming from full.
        repeat (8) applyStimulus(1'b1, 1'b0, 31'h0, 1'b1);

        // Redirect with three entries queued.
        applyStimulus(1'b0, 1'b0, 31'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 31'h200, 1'b0);
        checkOutput("pre_redirect_count", 64'(bus.count), 64'(3));
        applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        checkOutput("redir_count", 64'(bus.count), 64'(0));
        checkOutput("redir_valid", 64'(bus.instr_valid), 64'(0));
        checkOutput("redir_addr", 64'(bus.mem_rd0_addr), 64'h200);
        applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        checkOutput("redir_head_valid", 64'(bus.instr_valid), 64'(1));
        checkOutput("redir_head_pc", 64'(bus.instr_pc), 64'h200);

        // Drain with fetch disabled, then resume.
        applyStimulus(1'b0, 1'b0, 31'h0, 1'b1);
        checkOutput("drain_count", 64'(bus.count), 64'(2));
        repeat (3) applyStimulus(1'b0, 1'b0, 31'h0, 1'b1);
        checkOutput("drained_valid", 64'(bus.instr_valid), 64'(0));
        checkOutput("frozen_addr", 64'(bus.mem_rd0_addr), 64'h202);
        repeat (4) applyStimulus(1'b1, 1'b0, 31'h0, 1'b1);

        // Fetch address wrap.
        applyStimulus(1'b1, 1'b1, 31'h7FFFFFFE, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 31'h0, 1'b1);

        // Asynchronous reset with two entries queued.
        applyStimulus(1'b1, 1'b1, 31'h40, 1'b0);
        applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 31'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 31'h0, 1'b0);
        checkOutput("pre_reset_count", 64'(bus.count), 64'(2));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_valid", 64'(bus.instr_valid), 64'(0));
        checkOutput("async_count", 64'(bus.count), 64'(0));
        checkOutput("async_addr", 64'(bus.mem_rd0_addr), 64'(RESET_PC));
        @(posedge clk);
        #1 reset = 1'b0;

        // Random traffic.
        repeat (500) begin
            logic [30:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (31'h7FFFFFFC + 31'($urandom_range(0, 3)))
                                               : 31'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc,
                          $urandom_range(0, 2) != 0);
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
